// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C target. Oversamples SCL/SDA, detects START/STOP,
// matches the write address, ACKs every byte and strobes out received bytes.
module i2c_slave_rx #(
    parameter logic [7:0]  ADDR        = 8'h78,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] DATA,
    output logic       DATA_VALID,
    output logic       FIRST_BYTE,
    output logic       BUSY,
    output logic       STOP_SEEN
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK,
        S_IGNORE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [BYTE_W-1:0] shift, shift_n;
    logic [BYTE_W-1:0] data_n;
    logic              ack_half, ack_half_n;
    logic              sda_low, sda_low_n;
    logic              first_flag, first_flag_n;
    logic              busy_n, data_valid_n, first_byte_n, stop_seen_n;

    // Open-drain data line: only ever pulled low for ACK.
    assign SDA = sda_low ? 1'b0 : 1'bz;

    // Input synchronisers plus one-cycle-delayed copies for edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output logic; bus conditions take priority over bit traffic.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        ack_half_n   = ack_half;
        sda_low_n    = sda_low;
        busy_n       = BUSY;
        first_flag_n = first_flag;
        data_n       = DATA;
        data_valid_n = 1'b0;
        first_byte_n = FIRST_BYTE;
        stop_seen_n  = 1'b0;

        if (start_det) begin
            state_n    = S_ADDR;
            bit_cnt_n  = '0;
            busy_n     = 1'b0;
            sda_low_n  = 1'b0;
            ack_half_n = 1'b0;
        end else if (stop_det) begin
            state_n     = S_IDLE;
            bit_cnt_n   = '0;
            busy_n      = 1'b0;
            sda_low_n   = 1'b0;
            ack_half_n  = 1'b0;
            stop_seen_n = BUSY;
        end else begin
            case (state)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_n = {shift[BYTE_W-2:0], sda_s};
                        if (bit_cnt == CNT_W'(7)) begin
                            if (shift_n[7:1] == ADDR[7:1] && !shift_n[0]) begin
                                state_n = S_ADDR_ACK;
                            end else begin
                                state_n = S_IGNORE;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (scl_rise) begin
                        shift_n = {shift[BYTE_W-2:0], sda_s};
                        if (bit_cnt == CNT_W'(7)) begin
                            data_n       = shift_n;
                            data_valid_n = 1'b1;
                            first_byte_n = first_flag;
                            first_flag_n = 1'b0;
                            state_n      = S_DATA_ACK;
                        end else begin
                            bit_cnt_n = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    // First SCL fall starts the ACK, second fall ends the 9th clock.
                    if (scl_fall) begin
                        if (!ack_half) begin
                            sda_low_n  = 1'b1;
                            ack_half_n = 1'b1;
                        end else begin
                            sda_low_n  = 1'b0;
                            ack_half_n = 1'b0;
                            bit_cnt_n  = '0;
                            state_n    = S_DATA;
                            if (state == S_ADDR_ACK) begin
                                busy_n       = 1'b1;
                                first_flag_n = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt    <= '0;
            shift      <= '0;
            ack_half   <= 1'b0;
            sda_low    <= 1'b0;
            first_flag <= 1'b0;
            DATA       <= '0;
            DATA_VALID <= 1'b0;
            FIRST_BYTE <= 1'b0;
            BUSY       <= 1'b0;
            STOP_SEEN  <= 1'b0;
        end else begin
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            ack_half   <= ack_half_n;
            sda_low    <= sda_low_n;
            first_flag <= first_flag_n;
            DATA       <= data_n;
            DATA_VALID <= data_valid_n;
            FIRST_BYTE <= first_byte_n;
            BUSY       <= busy_n;
            STOP_SEEN  <= stop_seen_n;
        end
    end

endmodule
